// File: rtl/uart_rx_if.sv
// Valid/ready handshake carrying received words from the UART receiver to its consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver driven by a shared oversampling tick: synchronises rx, validates the start bit,
// samples data LSB-first at bit centre, checks the stop bit and hands words over valid/ready.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      tick,
    input  logic      rx,
    uart_rx_if.master bus,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state, state_next;
    logic                 rs_meta, rs;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 half_hit, bit_hit;
    logic                 word_done, stop_bad;

    assign half_hit = (tcnt == HALF_LAST);
    assign bit_hit  = (tcnt == BIT_LAST);

    // Idle-high reset value keeps a released reset from looking like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rs_meta <= rx;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                S_IDLE:  if (!rs) state_next = S_START;
                S_START: if (half_hit) state_next = rs ? S_IDLE : S_DATA;
                S_DATA:  if (bit_hit && bcnt == LAST_BIT) state_next = S_STOP;
                S_STOP:  if (bit_hit) state_next = rs ? S_IDLE : S_BREAK;
                S_BREAK: if (rs) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        word_done = (state == S_STOP) && tick && bit_hit && rs;
        stop_bad  = (state == S_STOP) && tick && bit_hit && !rs;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt      <= '0;
            bcnt      <= '0;
            shift_reg <= '0;
        end else if (tick) begin
            case (state)
                S_IDLE: tcnt <= '0;
                S_START: begin
                    if (half_hit) begin
                        tcnt <= '0;
                        bcnt <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_hit) begin
                        shift_reg <= {rs, shift_reg[DATA_BITS-1:1]};
                        tcnt      <= '0;
                        bcnt      <= bcnt + 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_STOP:  tcnt <= bit_hit ? '0 : tcnt + 1'b1;
                default: tcnt <= '0;
            endcase
        end
    end

    // A word arriving while the previous one is still pending is dropped, not overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= word_done && bus.rx_valid && !bus.rx_ready;
            if (word_done && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data  <= shift_reg;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end
endmodule
